reg_file_sb: RTL

Parametrised successor to the single-write, two-read register file. Adds N read ports, two write ports with fixed priority, an optional write-to-read bypass, reset-cleared contents, and a per-register pending scoreboard for pipelined hazard detection. Sits in the datapath decode stage. Read ports feed operand fetch; write ports take the ALU and load writebacks.

---
 rtl/reg_file_pkg.sv | 21 ++
 rtl/reg_file_sb_scoreboard.sv | 45 ++++
 rtl/reg_file_sb.sv | 74 +++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants, types and the address-compare helper for the
// scoreboarded register file.
package reg_file_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 16;
  localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

  // Widest address the compare helper accepts; callers zero-extend into it.
  localparam int MATCH_W = 16;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  function automatic logic addr_match(input logic en,
                                      input logic [MATCH_W-1:0] a,
                                      input logic [MATCH_W-1:0] b);
    return en && (a == b);
  endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register pending bits: a reserve marks a register as awaiting its
// producer, a writeback clears it, and a same-cycle reserve beats the write.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  input  logic                wr_en0,
  input  logic [ADDR_W-1:0]   wr_addr0,
  input  logic                wr_en1,
  input  logic [ADDR_W-1:0]   wr_addr1,
  output logic [NUM_REGS-1:0] pending
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_match(rsv_en, MATCH_W'(rsv_addr), MATCH_W'(i))) begin
        pending_d[i] = 1'b1;
      end else if (addr_match(wr_en0, MATCH_W'(wr_addr0), MATCH_W'(i)) ||
                   addr_match(wr_en1, MATCH_W'(wr_addr1), MATCH_W'(i))) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with two prioritised write ports, optional
// write-to-read forwarding and a pending scoreboard for hazard detection.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en0,
  input  logic [ADDR_W-1:0]        wr_addr0,
  input  logic [DATA_W-1:0]        wr_data0,
  input  logic                     wr_en1,
  input  logic [ADDR_W-1:0]        wr_addr1,
  input  logic [DATA_W-1:0]        wr_data1,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  output logic [NUM_REGS-1:0]      pending
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  // Port 1 is applied last so it wins a same-address dual write.
  always_comb begin
    mem_d = mem_q;
    if (wr_en0) mem_d[wr_addr0] = wr_data0;
    if (wr_en1) mem_d[wr_addr1] = wr_data1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  reg_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en0   (wr_en0),
    .wr_addr0 (wr_addr0),
    .wr_en1   (wr_en1),
    .wr_addr1 (wr_addr1),
    .pending  (pending)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0;
    logic              hit1;

    assign ra   = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit1 = (BYPASS != 0) && addr_match(wr_en1, MATCH_W'(wr_addr1), MATCH_W'(ra));
    assign hit0 = (BYPASS != 0) && addr_match(wr_en0, MATCH_W'(wr_addr0), MATCH_W'(ra));

    // Reset masks forwarding too, so every read is 0 and ready while held.
    assign rd_data[k*DATA_W +: DATA_W] = !reset_n ? '0       :
                                         hit1     ? wr_data1 :
                                         hit0     ? wr_data0 : mem_q[ra];
    assign rd_ready[k] = !reset_n || hit1 || hit0 || !pending[ra];
  end

endmodule
